// File: rtl/control_turnos.sv
// control_turnos: turn controller for a board game shared by NUM_JUG players.
// Accepts one dice value per turn through a valid/ready handshake, moves the
// current player (overshooting META is a lost move), detects the winner and
// rotates the turn round-robin.
//
// Optional feature macro: TURNO_EXTRA_EN
//   defined   -> a non-winning 6 grants an extra turn, at most 2 in a row.
//   undefined -> the turn always passes to the next player.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high reset
//   dado_valid    in   dice value presented
//   dado[2:0]     in   dice value, legal 1..6
//   dado_ready    out  dice value accepted this cycle (ESPERA only)
//   cuadros[8:0]  out  board increment, nonzero only in MOVER of a legal move
//   sel_jugador   out  index of the player whose turn it is
//   posicion[8:0] out  registered position of sel_jugador
//   turno_fin     out  one-cycle pulse when a turn completes
//   error_dado    out  one-cycle pulse after an illegal dice value (0 or 7)
//   ganador_valid out  sticky, a player reached META
//   ganador[1:0]  out  winning player index
module control_turnos #(
    parameter int unsigned NUM_JUG = 4,
    parameter logic [8:0]  META    = 9'd63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dado_valid,
    input  logic [2:0] dado,
    output logic       dado_ready,
    output logic [8:0] cuadros,
    output logic [1:0] sel_jugador,
    output logic [8:0] posicion,
    output logic       turno_fin,
    output logic       error_dado,
    output logic       ganador_valid,
    output logic [1:0] ganador
);

    typedef enum logic [2:0] {Espera, Mover, Verificar, Siguiente, Fin} estado_e;

    estado_e    estado_q, estado_d;
    logic [2:0] dado_q, dado_d;
    logic [8:0] pos_q [NUM_JUG];
    logic [1:0] sel_q, sel_d;
    logic       err_q, err_d;
    logic       gan_valid_q, gan_valid_d;
    logic [1:0] gan_q, gan_d;
    logic       mover_en;
    logic       dado_ok;
    logic [9:0] suma;
    logic [1:0] sel_sig;

`ifdef TURNO_EXTRA_EN
    logic [1:0] extra_q, extra_d;
`endif

    assign posicion = pos_q[sel_q];
    assign dado_ok  = (dado != 3'd0) && (dado != 3'd7);
    // 10-bit sum so a move near 511 cannot wrap and look legal.
    assign suma     = {1'b0, posicion} + {7'b0, dado_q};
    assign sel_sig  = (sel_q == 2'(NUM_JUG - 1)) ? 2'd0 : sel_q + 2'd1;

    always_comb begin
        estado_d    = estado_q;
        dado_d      = dado_q;
        sel_d       = sel_q;
        err_d       = 1'b0;
        gan_valid_d = gan_valid_q;
        gan_d       = gan_q;
        mover_en    = 1'b0;
        dado_ready  = 1'b0;
        cuadros     = 9'd0;
        turno_fin   = 1'b0;
`ifdef TURNO_EXTRA_EN
        extra_d     = extra_q;
`endif
        unique case (estado_q)
            Espera: begin
                dado_ready = 1'b1;
                if (dado_valid) begin
                    if (dado_ok) begin
                        dado_d   = dado;
                        estado_d = Mover;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            Mover: begin
                // Overshoot: the move is lost, cuadros stays 0.
                if (suma <= {1'b0, META}) begin
                    cuadros  = {6'b0, dado_q};
                    mover_en = 1'b1;
                end
                estado_d = Verificar;
            end
            Verificar: begin
                if (posicion == META) begin
                    gan_d       = sel_q;
                    gan_valid_d = 1'b1;
                    estado_d    = Fin;
                end else begin
                    estado_d = Siguiente;
                end
            end
            Siguiente: begin
                turno_fin = 1'b1;
`ifdef TURNO_EXTRA_EN
                if (dado_q == 3'd6 && extra_q != 2'd2) begin
                    extra_d = extra_q + 2'd1;
                end else begin
                    extra_d = 2'd0;
                    sel_d   = sel_sig;
                end
`else
                sel_d = sel_sig;
`endif
                estado_d = Espera;
            end
            Fin: begin
                estado_d = Fin;
            end
            default: estado_d = Espera;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= Espera;
            dado_q      <= 3'd0;
            sel_q       <= 2'd0;
            err_q       <= 1'b0;
            gan_valid_q <= 1'b0;
            gan_q       <= 2'd0;
            for (int i = 0; i < NUM_JUG; i++) begin
                pos_q[i] <= 9'd0;
            end
`ifdef TURNO_EXTRA_EN
            extra_q     <= 2'd0;
`endif
        end else begin
            estado_q    <= estado_d;
            dado_q      <= dado_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
            gan_valid_q <= gan_valid_d;
            gan_q       <= gan_d;
            if (mover_en) begin
                pos_q[sel_q] <= suma[8:0];
            end
`ifdef TURNO_EXTRA_EN
            extra_q     <= extra_d;
`endif
        end
    end

    assign sel_jugador   = sel_q;
    assign error_dado    = err_q;
    assign ganador_valid = gan_valid_q;
    assign ganador       = gan_q;

endmodule

// File: tb/tb_control_turnos.sv
// Directed self-checking bench for control_turnos (NUM_JUG=4, META=63).
module tb_control_turnos;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dado_valid = 1'b0;
    logic [2:0] dado = 3'd0;
    logic       dado_ready;
    logic [8:0] cuadros;
    logic [1:0] sel_jugador;
    logic [8:0] posicion;
    logic       turno_fin;
    logic       error_dado;
    logic       ganador_valid;
    logic [1:0] ganador;

    int n_chk = 0;
    int n_fail = 0;
    int n_tf = 0;

    control_turnos dut (
        .clk          (clk),
        .reset        (reset),
        .dado_valid   (dado_valid),
        .dado         (dado),
        .dado_ready   (dado_ready),
        .cuadros      (cuadros),
        .sel_jugador  (sel_jugador),
        .posicion     (posicion),
        .turno_fin    (turno_fin),
        .error_dado   (error_dado),
        .ganador_valid(ganador_valid),
        .ganador      (ganador)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (turno_fin) n_tf++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dado_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Offer v and complete the handshake; returns with the DUT in MOVER.
    task automatic tirar(input logic [2:0] v);
        int espera = 0;
        while (!dado_ready && espera < 20) begin
            step();
            espera++;
        end
        if (!dado_ready) chk("ready_timeout", 0, 1);
        dado = v;
        dado_valid = 1'b1;
        step();
        dado_valid = 1'b0;
    endtask

    // Full non-winning turn: MOVER, VERIFICAR, SIGUIENTE, back to ESPERA.
    task automatic turno(input logic [2:0] v, input logic [8:0] exp_c,
                         input logic [8:0] exp_p, input string tag);
        tirar(v);
        chk({tag, "_cuadros"}, cuadros, exp_c);
        step();
        chk({tag, "_posicion"}, posicion, exp_p);
        step();
        chk({tag, "_turno_fin"}, turno_fin, 1);
        step();
    endtask

    initial begin
        // Reset state.
        do_reset();
        chk("rst_ready", dado_ready, 1);
        chk("rst_sel", sel_jugador, 0);
        chk("rst_pos", posicion, 0);
        chk("rst_cuadros", cuadros, 0);
        chk("rst_turno_fin", turno_fin, 0);
        chk("rst_error", error_dado, 0);
        chk("rst_gan_valid", ganador_valid, 0);
        chk("rst_ganador", ganador, 0);

        // Two moves: 3 then 4.
        turno(3'd3, 9'd3, 9'd3, "p0_d3");
        turno(3'd4, 9'd4, 9'd4, "p1_d4");
        chk("sel_after_two", sel_jugador, 2);
        chk("ready_again", dado_ready, 1);

        // Four players roll 1 each; turn wraps to 0.
        do_reset();
        n_tf = 0;
        turno(3'd1, 9'd1, 9'd1, "wrap_p0");
        turno(3'd1, 9'd1, 9'd1, "wrap_p1");
        turno(3'd1, 9'd1, 9'd1, "wrap_p2");
        chk("sel_p3", sel_jugador, 3);
        turno(3'd1, 9'd1, 9'd1, "wrap_p3");
        chk("sel_wrap", sel_jugador, 0);
        chk("turno_fin_count", n_tf, 4);
        chk("p0_pos_wrap", posicion, 1);

        // Illegal dice values 0 and 7.
        dado = 3'd0;
        dado_valid = 1'b1;
        step();
        dado_valid = 1'b0;
        chk("err0_pulse", error_dado, 1);
        chk("err0_ready", dado_ready, 1);
        chk("err0_sel", sel_jugador, 0);
        step();
        chk("err0_clear", error_dado, 0);
        chk("err0_cuadros", cuadros, 0);
        dado = 3'd7;
        dado_valid = 1'b1;
        step();
        dado_valid = 1'b0;
        chk("err7_pulse", error_dado, 1);
        chk("err7_ready", dado_ready, 1);
        step();
        chk("err7_clear", error_dado, 0);
        chk("err7_pos", posicion, 1);
        turno(3'd2, 9'd2, 9'd3, "after_err");

        // Reset while in MOVER discards the move.
        do_reset();
        tirar(3'd5);
        chk("mover_cuadros", cuadros, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mover_ready", dado_ready, 1);
        chk("rst_mover_pos", posicion, 0);
        chk("rst_mover_sel", sel_jugador, 0);
        step();
        chk("rst_mover_pos2", posicion, 0);

        // Sequence 6,6,6,2.
        do_reset();
`ifdef TURNO_EXTRA_EN
        turno(3'd6, 9'd6, 9'd6, "x_6a");
        chk("x_sel_a", sel_jugador, 0);
        turno(3'd6, 9'd6, 9'd12, "x_6b");
        chk("x_sel_b", sel_jugador, 0);
        turno(3'd6, 9'd6, 9'd18, "x_6c");
        chk("x_sel_c", sel_jugador, 1);
        turno(3'd2, 9'd2, 9'd2, "x_p1_2");
        chk("x_sel_d", sel_jugador, 2);
`else
        turno(3'd6, 9'd6, 9'd6, "x_6a");
        chk("x_sel_a", sel_jugador, 1);
        turno(3'd6, 9'd6, 9'd6, "x_6b");
        chk("x_sel_b", sel_jugador, 2);
        turno(3'd6, 9'd6, 9'd6, "x_6c");
        chk("x_sel_c", sel_jugador, 3);
        turno(3'd2, 9'd2, 9'd2, "x_p3_2");
        chk("x_sel_d", sel_jugador, 0);
`endif

        // Player 0 climbs to 60 with twelve 5s, others roll 1.
        do_reset();
        for (int r = 0; r < 12; r++) begin
            turno(3'd5, 9'd5, 9'(5 * (r + 1)), "climb_p0");
            for (int p = 1; p < 4; p++) begin
                turno(3'd1, 9'd1, 9'(r + 1), "climb_px");
            end
        end
        chk("climb_sel", sel_jugador, 0);
        chk("climb_pos", posicion, 60);
        // Overshoot: 60+5 > 63.
        turno(3'd5, 9'd0, 9'd60, "overshoot");
        chk("overshoot_gan", ganador_valid, 0);
        for (int p = 1; p < 4; p++) begin
            turno(3'd1, 9'd1, 9'd13, "after_over");
        end
        // Exact hit: 60+3 = 63.
        tirar(3'd3);
        chk("win_cuadros", cuadros, 3);
        step();
        chk("win_pos", posicion, 63);
        chk("win_gan_pre", ganador_valid, 0);
        step();
        chk("win_gan_valid", ganador_valid, 1);
        chk("win_ganador", ganador, 0);
        chk("win_turno_fin", turno_fin, 0);
        chk("fin_ready", dado_ready, 0);
        // FIN ignores further dice, legal or not.
        dado = 3'd2;
        dado_valid = 1'b1;
        step();
        chk("fin_cuadros", cuadros, 0);
        dado = 3'd0;
        step();
        chk("fin_error", error_dado, 0);
        step();
        dado_valid = 1'b0;
        chk("fin_error2", error_dado, 0);
        chk("fin_pos", posicion, 63);
        chk("fin_sel", sel_jugador, 0);
        chk("fin_sticky", ganador_valid, 1);
        chk("fin_ready2", dado_ready, 0);

        // Reset leaves FIN.
        do_reset();
        chk("post_fin_ready", dado_ready, 1);
        chk("post_fin_gan", ganador_valid, 0);
        chk("post_fin_pos", posicion, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/control_turnos.md
CONTROL_TURNOS -- requirements
Module: control_turnos

Interface
REQ-001 Parameter NUM_JUG, default 4, number of players sharing the board; legal range 2..4.
REQ-002 Parameter META, default 9'd63, goal square; legal range 7..511.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dado_valid  input  1  dice value presented this cycle.
REQ-006 dado  input  3  dice value; legal 1..6.
REQ-007 dado_ready  output  1  block accepts a dice value this cycle.
REQ-008 cuadros  output  9  increment for the board accumulator; nonzero for exactly one cycle per accepted move, else 0.
REQ-009 sel_jugador  output  2  index of player whose turn it is.
REQ-010 posicion  output  9  registered position of sel_jugador.
REQ-011 turno_fin  output  1  one-cycle pulse when a turn completes.
REQ-012 error_dado  output  1  one-cycle pulse when an illegal dice value is offered.
REQ-013 ganador_valid  output  1  sticky; a player has reached META.
REQ-014 ganador  output  2  winning player index; valid while ganador_valid=1.

Function
REQ-015 FSM states SHALL be ESPERA, MOVER, VERIFICAR, SIGUIENTE, FIN.
REQ-016 ESPERA: dado_ready=1; all other states dado_ready=0.
REQ-017 Handshake: transfer occurs on an edge with dado_valid=1, dado_ready=1, dado in 1..6; value latched, FSM -> MOVER.
REQ-018 dado of 0 or 7 with dado_valid=1 in ESPERA: not accepted, error_dado pulses next cycle, FSM stays in ESPERA, turn not consumed.
REQ-019 MOVER (one cycle): if posicion+dado <= META, cuadros=dado and player position register adds dado at end of cycle; otherwise (overshoot) cuadros=0 and position unchanged.
REQ-020 Arithmetic: 10-bit compare of posicion+dado against META; no wrap of the 9-bit position.
REQ-021 VERIFICAR (one cycle): updated position == META -> ganador=sel_jugador, ganador_valid=1, FSM -> FIN; else -> SIGUIENTE.
REQ-022 SIGUIENTE (one cycle): turno_fin=1; sel_jugador advances round-robin 0..NUM_JUG-1 wrapping to 0 (subject to REQ-029); FSM -> ESPERA.
REQ-023 Latency: accept at edge k -> cuadros nonzero in cycle k..k+1 (MOVER), posicion updated after edge k+1, turno_fin in SIGUIENTE, dado_ready=1 again three cycles after accept.
REQ-024 FIN: absorbing until reset; dado_ready=0, cuadros=0, dado_valid ignored, no error_dado pulses.
REQ-025 Per-player position registers: NUM_JUG x 9 bits; posicion mux driven by sel_jugador.

Reset
REQ-026 reset=1 at a rising edge SHALL force state ESPERA, all positions 0, sel_jugador=0, cuadros=0, turno_fin=0, error_dado=0, ganador_valid=0, ganador=0, latched dice and extra-turn counter 0.
REQ-027 Reset SHALL take priority over every other event, including an in-flight move in MOVER or VERIFICAR; a partly applied move is discarded.
REQ-028 dado_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro TURNO_EXTRA_EN defined: an accepted 6 that does not win keeps sel_jugador unchanged in SIGUIENTE (extra turn), limited to 2 consecutive extra turns per player, then the turn passes; counter clears when the turn passes. turno_fin still pulses.
REQ-030 TURNO_EXTRA_EN undefined: sel_jugador always advances in SIGUIENTE; no extra-turn counter is built.

Verification
REQ-031 Reset, then dado=3 then dado=4, NUM_JUG=4 -> cuadros pulses 3 then 4, player0 pos=3, player1 pos=4, sel_jugador=2.
REQ-032 Four players each roll 1 -> sel_jugador wraps 3->0, turno_fin pulsed 4 times, all positions 1.
REQ-033 META=63, player0 at 60 rolls 5 -> cuadros=0, position stays 60; later rolls 3 -> position 63, ganador_valid=1, ganador=0, FIN ignores further dado_valid.
REQ-034 dado=0 and dado=7 offered in ESPERA -> error_dado pulse each, no state change, sel_jugador unchanged.
REQ-035 Reset asserted during MOVER -> all positions 0, ESPERA, dado_ready=1 after deassert.
REQ-036 TURNO_EXTRA_EN defined, player0 rolls 6,6,6,2 -> sel_jugador stays 0 for two extra turns, advances to 1 after third 6; player0 pos=18, player1 pos=2. Undefined: advances after each roll.
